// File: rtl/up_down_counter_n_pkg.sv
// Shared constants for the up/down counter: mode selectors and default width.
package up_down_counter_n_pkg;

  localparam int unsigned MODE_WRAP     = 0;
  localparam int unsigned MODE_SAT      = 1;
  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage : up_down_counter_n_pkg

// File: rtl/up_down_counter_n_if.sv
// Control/status bundle for the up/down counter. The master drives the
// requests; the slave (the counter) returns the count and status flags.
interface up_down_counter_n_if
  import up_down_counter_n_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             borrow;
  logic             at_max;
  logic             at_zero;

  modport master (
    output en, load, load_val, up, down,
    input  count, carry, borrow, at_max, at_zero
  );

  modport slave (
    input  en, load, load_val, up, down,
    output count, carry, borrow, at_max, at_zero
  );

endinterface : up_down_counter_n_if

// File: rtl/up_down_step.sv
// Next-state logic for the up/down counter. Purely combinational; the
// asynchronous clear is handled by the register stage in the top level.
module up_down_step
  import up_down_counter_n_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int unsigned      SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             down,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             next_carry,
  output logic             next_borrow
);

  localparam logic IsSat = (SATURATE == MODE_SAT);

  // Priority: load > en&up > en&down > hold; pulses only on a real wrap.
  always_comb begin
    next_count  = count;
    next_carry  = 1'b0;
    next_borrow = 1'b0;
    if (load) begin
      // Clamp so the count can never leave 0..MAX.
      next_count = (load_val > MAX) ? MAX : load_val;
    end else if (en && up) begin
      if (count >= MAX) begin
        if (IsSat) begin
          next_count = MAX;
        end else begin
          next_count = '0;
          next_carry = 1'b1;
        end
      end else begin
        next_count = count + 1'b1;
      end
    end else if (en && down) begin
      if (count == '0) begin
        if (IsSat) begin
          next_count  = '0;
        end else begin
          next_count  = MAX;
          next_borrow = 1'b1;
        end
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

endmodule : up_down_step

// File: rtl/up_down_counter_n.sv
// Modulo-(MAX+1) up/down counter with load, wrap or saturate behaviour,
// registered carry/borrow pulses and combinational terminal flags.
module up_down_counter_n
  import up_down_counter_n_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int unsigned      SATURATE = MODE_WRAP
) (
  input logic                clk,
  input logic                clear,
  up_down_counter_n_if.slave bus
);

  logic [WIDTH-1:0] r_count;
  logic             r_carry;
  logic             r_borrow;

  logic [WIDTH-1:0] w_next_count;
  logic             w_next_carry;
  logic             w_next_borrow;

  up_down_step #(
    .WIDTH    (WIDTH),
    .MAX      (MAX),
    .SATURATE (SATURATE)
  ) u_step (
    .count       (r_count),
    .up          (bus.up),
    .down        (bus.down),
    .en          (bus.en),
    .load        (bus.load),
    .load_val    (bus.load_val),
    .next_count  (w_next_count),
    .next_carry  (w_next_carry),
    .next_borrow (w_next_borrow)
  );

  // State register; clear acts immediately and drops any pending pulse.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_count  <= w_next_count;
      r_carry  <= w_next_carry;
      r_borrow <= w_next_borrow;
    end
  end

  assign bus.count   = r_count;
  assign bus.carry   = r_carry;
  assign bus.borrow  = r_borrow;
  assign bus.at_max  = (r_count == MAX);
  assign bus.at_zero = (r_count == '0);

endmodule : up_down_counter_n

// File: tb/tb_up_down_counter_n.sv
// Directed bench for up_down_counter_n across four parameterisations that
// share one clock: decade wrap, decade saturate, 4-bit full range, 8-bit.
module tb_up_down_counter_n;
  import up_down_counter_n_pkg::*;

  logic clk = 1'b0;
  logic clr_dec, clr_sat, clr_hex, clr_byte;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  up_down_counter_n_if #(.WIDTH(4)) if_dec  ();
  up_down_counter_n_if #(.WIDTH(4)) if_sat  ();
  up_down_counter_n_if #(.WIDTH(4)) if_hex  ();
  up_down_counter_n_if #(.WIDTH(8)) if_byte ();

  up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .SATURATE(MODE_WRAP)) u_dec (
    .clk (clk), .clear (clr_dec), .bus (if_dec)
  );
  up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .SATURATE(MODE_SAT)) u_sat (
    .clk (clk), .clear (clr_sat), .bus (if_sat)
  );
  up_down_counter_n #(.WIDTH(4), .MAX(4'd15), .SATURATE(MODE_WRAP)) u_hex (
    .clk (clk), .clear (clr_hex), .bus (if_hex)
  );
  up_down_counter_n #(.WIDTH(8), .MAX(8'd255), .SATURATE(MODE_WRAP)) u_byte (
    .clk (clk), .clear (clr_byte), .bus (if_byte)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned model;
    int          carries;

    {if_dec.en, if_dec.load, if_dec.up, if_dec.down}     = '0;
    {if_sat.en, if_sat.load, if_sat.up, if_sat.down}     = '0;
    {if_hex.en, if_hex.load, if_hex.up, if_hex.down}     = '0;
    {if_byte.en, if_byte.load, if_byte.up, if_byte.down} = '0;
    if_dec.load_val = '0; if_sat.load_val = '0; if_hex.load_val = '0; if_byte.load_val = '0;
    {clr_dec, clr_sat, clr_hex, clr_byte} = 4'b1111;

    // Reset state
    #3;
    check("rst_count",   32'(if_dec.count), 0);
    check("rst_carry",   32'(if_dec.carry), 0);
    check("rst_borrow",  32'(if_dec.borrow), 0);
    check("rst_at_zero", 32'(if_dec.at_zero), 1);
    check("rst_at_max",  32'(if_dec.at_max), 0);
    tick();
    {clr_dec, clr_sat, clr_hex, clr_byte} = 4'b0000;

    // Decade wrap: 1..9 then 0 with a single carry
    if_dec.en = 1'b1; if_dec.up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("dec_count_%0d", i), 32'(if_dec.count), i % 10);
      check($sformatf("dec_carry_%0d", i), 32'(if_dec.carry), (i == 10) ? 1 : 0);
      check($sformatf("dec_atmax_%0d", i), 32'(if_dec.at_max), (i == 9) ? 1 : 0);
    end

    // Down wrap from 0
    if_dec.up = 1'b0; if_dec.down = 1'b1;
    tick();
    check("dw_count",  32'(if_dec.count), 9);
    check("dw_borrow", 32'(if_dec.borrow), 1);
    check("dw_carry",  32'(if_dec.carry), 0);
    check("dw_at_max", 32'(if_dec.at_max), 1);
    if_dec.en = 1'b0;
    tick();
    check("hold_count",  32'(if_dec.count), 9);
    check("hold_borrow", 32'(if_dec.borrow), 0);

    // Priority and clamp
    if_dec.en = 1'b1; if_dec.up = 1'b1; if_dec.down = 1'b1;
    if_dec.load = 1'b1; if_dec.load_val = 4'd14;
    tick();
    check("clamp_count", 32'(if_dec.count), 9);
    check("clamp_carry", 32'(if_dec.carry), 0);
    if_dec.load = 1'b0;
    tick();
    check("updn_count", 32'(if_dec.count), 0);
    check("updn_carry", 32'(if_dec.carry), 1);
    if_dec.en = 1'b0; if_dec.down = 1'b0;
    tick();
    check("en0_count", 32'(if_dec.count), 0);
    check("en0_carry", 32'(if_dec.carry), 0);
    if_dec.load = 1'b1; if_dec.load_val = 4'd5;
    tick();
    check("load5_count", 32'(if_dec.count), 5);
    if_dec.load = 1'b0; if_dec.en = 1'b1; if_dec.up = 1'b0; if_dec.down = 1'b1;
    tick();
    check("dec_down_count", 32'(if_dec.count), 4);
    check("dec_down_borrow", 32'(if_dec.borrow), 0);

    // Saturate mode
    if_sat.en = 1'b1; if_sat.up = 1'b1; if_sat.load = 1'b1; if_sat.load_val = 4'd9;
    tick();
    check("sat_load9", 32'(if_sat.count), 9);
    if_sat.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_up_count_%0d", i), 32'(if_sat.count), 9);
      check($sformatf("sat_up_carry_%0d", i), 32'(if_sat.carry), 0);
    end
    check("sat_at_max", 32'(if_sat.at_max), 1);
    if_sat.load = 1'b1; if_sat.load_val = 4'd0;
    tick();
    check("sat_load0", 32'(if_sat.count), 0);
    if_sat.load = 1'b0; if_sat.up = 1'b0; if_sat.down = 1'b1;
    tick();
    check("sat_dn_count",  32'(if_sat.count), 0);
    check("sat_dn_borrow", 32'(if_sat.borrow), 0);
    check("sat_at_zero",   32'(if_sat.at_zero), 1);

    // Asynchronous clear between edges
    if_hex.en = 1'b1; if_hex.up = 1'b1;
    repeat (7) tick();
    check("hex_at7", 32'(if_hex.count), 7);
    #2 clr_hex = 1'b1;
    #1;
    check("aclr_count",   32'(if_hex.count), 0);
    check("aclr_carry",   32'(if_hex.carry), 0);
    check("aclr_borrow",  32'(if_hex.borrow), 0);
    check("aclr_at_zero", 32'(if_hex.at_zero), 1);
    #1 clr_hex = 1'b0;
    tick();
    check("aclr_resume", 32'(if_hex.count), 1);

    // Clear cancels a pending carry pulse
    if_hex.load = 1'b1; if_hex.load_val = 4'd15;
    tick();
    check("hex_load15", 32'(if_hex.count), 15);
    if_hex.load = 1'b0;
    tick();
    check("hex_wrap_count", 32'(if_hex.count), 0);
    check("hex_wrap_carry", 32'(if_hex.carry), 1);
    #2 clr_hex = 1'b1;
    #1;
    check("cancel_carry", 32'(if_hex.carry), 0);
    #1 clr_hex = 1'b0;
    tick();
    check("cancel_resume", 32'(if_hex.count), 1);
    check("cancel_carry2", 32'(if_hex.carry), 0);

    // Clear held across an edge ignores load
    clr_hex = 1'b1; if_hex.load = 1'b1; if_hex.load_val = 4'd5;
    tick();
    check("clr_hold_count",  32'(if_hex.count), 0);
    check("clr_hold_at_max", 32'(if_hex.at_max), 0);
    clr_hex = 1'b0; if_hex.load = 1'b0; if_hex.en = 1'b0;

    // Full 8-bit range against a reference model
    model = 0; carries = 0;
    if_byte.en = 1'b1; if_byte.up = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      model = (model + 1) % 256;
      if (if_byte.carry) carries++;
      check($sformatf("byte_count_%0d", i), 32'(if_byte.count), model);
      check($sformatf("byte_carry_%0d", i), 32'(if_byte.carry), (model == 0) ? 1 : 0);
    end
    check("byte_final", 32'(if_byte.count), 0);
    check("byte_carries", 32'(carries), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_up_down_counter_n
